// File: rtl/tm_mem_arbiter.sv
// Arbiter sharing the single-port tape/state memory between the TM core sequencer and the host/debug port.
// Optional macro TM_ARB_ROUND_ROBIN_EN: round-robin arbitration in ARB instead of core priority with starvation override.
module tm_mem_arbiter #(
   parameter int DW         = 4,
   parameter int W          = 64,
   parameter int AW         = $clog2(W),
   parameter int STARVE_MAX = 4
) (
   input  logic          clock,
   input  logic          Reset,
   input  logic          core_req,
   input  logic          core_we,
   input  logic          core_lock,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          core_gnt,
   output logic [DW-1:0] core_rdata,
   output logic          core_rvalid,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic [DW-1:0] host_rdata,
   output logic          host_rvalid,
   output logic          mem_re,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          locked,
   output logic          host_starved
);

   typedef enum logic {ARB, LOCK} state_t;

   state_t        state_q, state_d;
   logic          arbMode;
   logic          coreRvalid_q, hostRvalid_q;
   logic [DW-1:0] coreRdata_q, hostRdata_q;

   // Dropping core_lock while in LOCK releases the memory in that same cycle.
   assign arbMode = (state_q == ARB) | ~core_lock;

`ifdef TM_ARB_ROUND_ROBIN_EN
   logic lastHost_q, lastHost_d;

   always_comb begin
      core_gnt = 1'b0;
      host_gnt = 1'b0;
      if (!arbMode) begin
         core_gnt = core_req;
      end else if (core_req && host_req) begin
         core_gnt = lastHost_q;
         host_gnt = ~lastHost_q;
      end else begin
         core_gnt = core_req;
         host_gnt = host_req;
      end
   end

   always_comb begin
      lastHost_d = lastHost_q;
      if (core_gnt) begin
         lastHost_d = 1'b0;
      end else if (host_gnt) begin
         lastHost_d = 1'b1;
      end
   end

   // Starting as "host last" lets the core win the first conflict after reset.
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         lastHost_q <= 1'b1;
      end else begin
         lastHost_q <= lastHost_d;
      end
   end

   assign host_starved = 1'b0;
`else
   logic [3:0] starveCnt_q, starveCnt_d;
   logic       starveHit;

   assign starveHit    = host_req & (starveCnt_q == 4'(STARVE_MAX));
   assign host_starved = starveHit;

   always_comb begin
      core_gnt = 1'b0;
      host_gnt = 1'b0;
      if (!arbMode) begin
         core_gnt = core_req;
      end else if (starveHit) begin
         host_gnt = 1'b1;
      end else if (core_req) begin
         core_gnt = 1'b1;
      end else if (host_req) begin
         host_gnt = 1'b1;
      end
   end

   // The count keeps running while locked so the host is forced in right after release.
   always_comb begin
      starveCnt_d = 4'd0;
      if (host_req && !host_gnt) begin
         if (starveCnt_q == 4'(STARVE_MAX)) begin
            starveCnt_d = starveCnt_q;
         end else begin
            starveCnt_d = starveCnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         starveCnt_q <= 4'd0;
      end else begin
         starveCnt_q <= starveCnt_d;
      end
   end
`endif

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      if (core_gnt) begin
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
      end else if (host_gnt) begin
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end
   end

   assign mem_re = (core_gnt & ~core_we) | (host_gnt & ~host_we);
   assign mem_we = (core_gnt & core_we) | (host_gnt & host_we);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB:     if (core_lock && core_gnt) state_d = LOCK;
         LOCK:    if (!core_lock) state_d = ARB;
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         state_q      <= ARB;
         coreRvalid_q <= 1'b0;
         hostRvalid_q <= 1'b0;
         coreRdata_q  <= '0;
         hostRdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         coreRvalid_q <= core_gnt & ~core_we;
         hostRvalid_q <= host_gnt & ~host_we;
         if (core_gnt && !core_we) begin
            coreRdata_q <= mem_rdata;
         end
         if (host_gnt && !host_we) begin
            hostRdata_q <= mem_rdata;
         end
      end
   end

   assign core_rvalid = coreRvalid_q;
   assign core_rdata  = coreRdata_q;
   assign host_rvalid = hostRvalid_q;
   assign host_rdata  = hostRdata_q;
   assign locked      = (state_q == LOCK);

endmodule

// File: tb/tb_tm_mem_arbiter.sv
// Scoreboard testbench for tm_mem_arbiter: directed vectors push expected grants/reads, a negedge monitor compares.
// Expected values follow TM_ARB_ROUND_ROBIN_EN when that macro is defined.
module tb_tm_mem_arbiter;

   localparam int DW = 4;
   localparam int W  = 64;
   localparam int AW = 6;
   localparam int SM = 4;
`ifdef TM_ARB_ROUND_ROBIN_EN
   localparam bit RR   = 1'b1;
   localparam int MAXW = 1;
`else
   localparam bit RR   = 1'b0;
   localparam int MAXW = SM;
`endif

   logic          clock, Reset;
   logic          core_req, core_we, core_lock;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata;
   logic          core_gnt, core_rvalid;
   logic [DW-1:0] core_rdata;
   logic          host_req, host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_gnt, host_rvalid;
   logic [DW-1:0] host_rdata;
   logic          mem_re, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          locked, host_starved;

   tm_mem_arbiter #(.DW(DW), .W(W), .AW(AW), .STARVE_MAX(SM)) dut (
      .clock(clock), .Reset(Reset),
      .core_req(core_req), .core_we(core_we), .core_lock(core_lock),
      .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .locked(locked), .host_starved(host_starved)
   );

   typedef struct {
      logic          c, h, st, lk, re, we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
   } gntExp_t;

   typedef struct {
      logic          isHost;
      logic [DW-1:0] data;
      int            due;
   } rdExp_t;

   gntExp_t gntQ[$];
   rdExp_t  rdQ[$];
   gntExp_t monE;
   rdExp_t  monR;
   int      compares = 0;
   int      fails = 0;
   int      cyc = 0;
   int      hostWait = 0;
   bit      randPhase = 1'b0;
   logic    cg, hg;
   logic [DW-1:0] mem [W];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural single-port memory: combinational read, write at the clock edge.
   assign mem_rdata = mem[mem_addr];
   always @(posedge clock) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      compares++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic cr, cwe, clk, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                                input logic hr, hwe, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                                input logic eC, eH, eSt, eLk, input int eRd);
      gntExp_t e;
      rdExp_t  r;
      @(posedge clock);
      #1;
      core_req = cr; core_we = cwe; core_lock = clk; core_addr = ca; core_wdata = cd;
      host_req = hr; host_we = hwe; host_addr = ha; host_wdata = hd;
      e.c    = eC;
      e.h    = eH;
      e.st   = eSt;
      e.lk   = eLk;
      e.re   = (eC & ~cwe) | (eH & ~hwe);
      e.we   = (eC & cwe) | (eH & hwe);
      e.addr = eC ? ca : (eH ? ha : '0);
      e.wd   = eC ? cd : (eH ? hd : '0);
      gntQ.push_back(e);
      if (eRd >= 0) begin
         r.isHost = eH;
         r.data   = DW'(eRd);
         r.due    = cyc + 1;
         rdQ.push_back(r);
      end
   endtask

   task automatic clearInputs();
      core_req = 0; core_we = 0; core_lock = 0; core_addr = '0; core_wdata = '0;
      host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
   endtask

   // Monitor: compares queued grant expectations each cycle and read data whenever a read is due.
   always @(negedge clock) begin
      if (gntQ.size() > 0) begin
         monE = gntQ.pop_front();
         checkOutput("core_gnt", int'(core_gnt), int'(monE.c));
         checkOutput("host_gnt", int'(host_gnt), int'(monE.h));
         checkOutput("host_starved", int'(host_starved), int'(monE.st));
         checkOutput("locked", int'(locked), int'(monE.lk));
         checkOutput("mem_re", int'(mem_re), int'(monE.re));
         checkOutput("mem_we", int'(mem_we), int'(monE.we));
         checkOutput("mem_addr", int'(mem_addr), int'(monE.addr));
         checkOutput("mem_wdata", int'(mem_wdata), int'(monE.wd));
      end
      if (!randPhase) begin
         if (rdQ.size() > 0 && rdQ[0].due == cyc) begin
            monR = rdQ.pop_front();
            if (monR.isHost) begin
               checkOutput("host_rvalid", int'(host_rvalid), 1);
               checkOutput("host_rdata", int'(host_rdata), int'(monR.data));
               checkOutput("core_rvalid_idle", int'(core_rvalid), 0);
            end else begin
               checkOutput("core_rvalid", int'(core_rvalid), 1);
               checkOutput("core_rdata", int'(core_rdata), int'(monR.data));
               checkOutput("host_rvalid_idle", int'(host_rvalid), 0);
            end
         end else begin
            checkOutput("unexpected_rvalid", int'(core_rvalid | host_rvalid), 0);
         end
      end
      checkOutput("single_grant", int'(core_gnt & host_gnt), 0);
      checkOutput("we_without_gnt", int'(mem_we & ~(core_gnt | host_gnt)), 0);
      if (randPhase) begin
         if (host_req) begin
            if (host_gnt) begin
               compares++;
               if (hostWait > MAXW) begin
                  fails++;
                  $display("[TB] FAIL host_wait_bound: waited %0d cycles, allowed %0d", hostWait, MAXW);
               end
               hostWait = 0;
            end else begin
               hostWait++;
            end
         end else begin
            hostWait = 0;
         end
      end
   end

   initial begin
      for (int i = 0; i < W; i++) mem[i] = '0;
      clearInputs();
      Reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("rst_locked", int'(locked), 0);
      checkOutput("rst_rvalid", int'(core_rvalid | host_rvalid), 0);
      checkOutput("rst_rdata", int'(core_rdata | host_rdata), 0);
      checkOutput("rst_starved", int'(host_starved), 0);
      @(posedge clock);
      #1 Reset = 1'b0;

      // Idle, then host program load and read-back.
      applyStimulus(0,0,0,0,0, 0,0,0,0, 0,0,0,0,-1);
      applyStimulus(0,0,0,0,0, 0,0,0,0, 0,0,0,0,-1);
      applyStimulus(0,0,0,0,0, 1,1,3,4'h5, 0,1,0,0,-1);
      applyStimulus(0,0,0,0,0, 1,0,3,0, 0,1,0,0,5);
      applyStimulus(0,0,0,0,0, 0,0,0,0, 0,0,0,0,-1);
      applyStimulus(1,1,0,10,4'h9, 0,0,0,0, 1,0,0,0,-1);

      // Continuous conflict: core reads addr 3 (=5), host reads addr 10 (=9).
      for (int i = 0; i < 10; i++) begin
         bit hw;
         hw = RR ? (i % 2 == 0) : (i % 5 == 4);
         applyStimulus(1,0,0,3,0, 1,0,10,0, !hw, hw, hw & !RR, 0, hw ? 9 : 5);
      end
      applyStimulus(0,0,0,0,0, 1,0,3,0, 0,1,0,0,5);

      // Lock: read-modify-write of addr 10 with the host held off, starvation saturating meanwhile.
      applyStimulus(1,0,1,10,0, 1,0,3,0, 1,0,0,0,9);
      applyStimulus(1,1,1,10,4'hA, 1,0,3,0, 1,0,0,1,-1);
      for (int j = 0; j < 4; j++) begin
         applyStimulus(0,0,1,0,0, 1,0,3,0, 0,0, (j >= 2) & !RR, 1, -1);
      end
      applyStimulus(1,0,0,3,0, 1,0,3,0, 0,1,!RR,1,5);
      applyStimulus(1,0,0,3,0, 1,0,10,0, 1,0,0,0,5);
      applyStimulus(0,0,0,0,0, 1,0,10,0, 0,1,0,0,10);

      // Reset arriving the cycle after a granted locked read drops its rvalid and the lock.
      applyStimulus(1,0,1,3,0, 0,0,0,0, 1,0,0,0,5);
      applyStimulus(1,0,1,3,0, 0,0,0,0, 1,0,0,1,-1);
      @(posedge clock);
      #1;
      Reset = 1'b1;
      clearInputs();
      @(posedge clock);
      #1 Reset = 1'b0;
      applyStimulus(0,0,0,0,0, 1,0,3,0, 0,1,0,0,5);
      applyStimulus(0,0,0,0,0, 0,0,0,0, 0,0,0,0,-1);
      applyStimulus(0,0,0,0,0, 0,0,0,0, 0,0,0,0,-1);

      // Random traffic without lock: invariants and host forward-progress bound.
      @(posedge clock);
      #1;
      randPhase = 1'b1;
      hostWait = 0;
      repeat (3000) begin
         @(negedge clock);
         cg = core_gnt;
         hg = host_gnt;
         @(posedge clock);
         #1;
         if (!core_req || cg) begin
            core_req   = 1'($urandom_range(0, 1));
            core_we    = 1'($urandom_range(0, 1));
            core_addr  = AW'($urandom_range(0, W - 1));
            core_wdata = DW'($urandom);
         end
         if (!host_req || hg) begin
            host_req   = 1'($urandom_range(0, 1));
            host_we    = 1'($urandom_range(0, 1));
            host_addr  = AW'($urandom_range(0, W - 1));
            host_wdata = DW'($urandom);
         end
      end
      @(posedge clock);
      #1 clearInputs();
      repeat (2) @(posedge clock);
      #1 randPhase = 1'b0;
      repeat (3) @(posedge clock);
      checkOutput("pending_reads_left", rdQ.size(), 0);
      checkOutput("pending_grants_left", gntQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule
